// File: rtl/ir_cmd_scheduler.sv
// rtl/ir_cmd_scheduler.sv - NEC IR command checker with repeat window and command FIFO
//
// Purpose:
//   Sits behind the NEC frame decoder. Each decoded frame is checked (command
//   against its inverted copy, optional address filter). Accepted commands and
//   honoured repeat codes are queued in a show-ahead FIFO and mirrored onto
//   LEDR. Every event ends with a one-cycle dec_rearm pulse back to the decoder.
//
// Ports:
//   CLOCK_50    in   system clock
//   RESET       in   asynchronous active-high reset
//   dec_valid   in   one-cycle pulse, frame fields below are valid
//   dec_addr    in   [7:0] decoded address
//   dec_cmd     in   [7:0] decoded command
//   dec_cmd_inv in   [7:0] decoded inverted command
//   dec_repeat  in   one-cycle pulse, repeat code seen
//   dec_rearm   out  one-cycle pulse, decoder returns to leader hunt
//   cmd_valid   out  FIFO non-empty
//   cmd_data    out  [7:0] command at FIFO head
//   cmd_repeat  out  head entry came from a repeat code
//   cmd_ready   in   consumer pops head when cmd_valid & cmd_ready
//   LEDR        out  [7:0] last accepted command
//   err_count   out  [7:0] rejected frames, saturating
//   overflow    out  sticky, an accepted command was dropped on a full FIFO
module ir_cmd_scheduler #(
  parameter int         FIFO_DEPTH    = 4,
  parameter int         REPEAT_WINDOW = 6000000,
  parameter bit         ADDR_FILTER   = 1'b0,
  parameter logic [7:0] ADDR_MATCH    = 8'h00
) (
  input  logic       CLOCK_50,
  input  logic       RESET,
  input  logic       dec_valid,
  input  logic [7:0] dec_addr,
  input  logic [7:0] dec_cmd,
  input  logic [7:0] dec_cmd_inv,
  input  logic       dec_repeat,
  output logic       dec_rearm,
  output logic       cmd_valid,
  output logic [7:0] cmd_data,
  output logic       cmd_repeat,
  input  logic       cmd_ready,
  output logic [7:0] LEDR,
  output logic [7:0] err_count,
  output logic       overflow
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int TW = $clog2(REPEAT_WINDOW + 1);
  localparam logic [TW-1:0] TIMER_LOAD = TW'(REPEAT_WINDOW);
  localparam logic [CW-1:0] DEPTH_C    = CW'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, CHECK, PUSH, REARM} state_t;

  state_t state_q, state_d;

  // Decoder strobes and fields are captured first so the FSM works from
  // registered copies; this gives the frame path its fixed edge timing.
  logic       in_valid_q, in_valid_d;
  logic       in_repeat_q, in_repeat_d;
  logic [7:0] in_addr_q, in_addr_d;
  logic [7:0] in_cmd_q, in_cmd_d;
  logic [7:0] in_inv_q, in_inv_d;

  // Frame under evaluation
  logic [7:0] addr_q, addr_d;
  logic [7:0] cmd_q, cmd_d;
  logic [7:0] inv_q, inv_d;
  logic       rpt_q, rpt_d;

  // Repeat bookkeeping
  logic [7:0]    last_cmd_q, last_cmd_d;
  logic          last_ok_q, last_ok_d;
  logic [TW-1:0] timer_q, timer_d;

  // Registered outputs
  logic [7:0] led_q, led_d;
  logic [7:0] err_q, err_d;
  logic       ovf_q, ovf_d;
  logic       rearm_q, rearm_d;
  logic       valid_q, valid_d;
  logic [8:0] head_q, head_d;

  // FIFO storage, entries are {repeat, cmd}
  logic [8:0]    mem_q [FIFO_DEPTH];
  logic [8:0]    mem_d [FIFO_DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;

  logic pop;
  logic push_en;
  logic frame_ok;

  always_comb begin
    in_valid_d  = dec_valid;
    in_repeat_d = dec_repeat;
    in_addr_d   = dec_addr;
    in_cmd_d    = dec_cmd;
    in_inv_d    = dec_cmd_inv;

    state_d    = state_q;
    addr_d     = addr_q;
    cmd_d      = cmd_q;
    inv_d      = inv_q;
    rpt_d      = rpt_q;
    last_cmd_d = last_cmd_q;
    last_ok_d  = last_ok_q;
    timer_d    = timer_q;
    led_d      = led_q;
    err_d      = err_q;
    ovf_d      = ovf_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    push_en    = 1'b0;

    pop      = valid_q & cmd_ready;
    frame_ok = ((cmd_q ^ inv_q) == 8'hFF) && (!ADDR_FILTER || (addr_q == ADDR_MATCH));

    // Repeat window; last_ok drops on the edge where the timer reaches zero.
    if (timer_q != '0) begin
      timer_d = timer_q - TW'(1);
      if (timer_q == TW'(1)) begin
        last_ok_d = 1'b0;
      end
    end

    case (state_q)
      IDLE: begin
        if (in_valid_q) begin
          addr_d  = in_addr_q;
          cmd_d   = in_cmd_q;
          inv_d   = in_inv_q;
          rpt_d   = 1'b0;
          state_d = CHECK;
        end else if (in_repeat_q) begin
          if (last_ok_q) begin
            cmd_d   = last_cmd_q;
            rpt_d   = 1'b1;
            state_d = PUSH;
          end else begin
            state_d = REARM;
          end
        end
      end
      CHECK: begin
        if (frame_ok) begin
          state_d = PUSH;
        end else begin
          if (err_q != 8'hFF) begin
            err_d = err_q + 8'd1;
          end
          state_d = REARM;
        end
      end
      PUSH: begin
        // A pop on the same edge frees the slot we are about to fill.
        if ((count_q < DEPTH_C) || pop) begin
          push_en = 1'b1;
        end else begin
          ovf_d = 1'b1;
        end
        led_d      = cmd_q;
        last_cmd_d = cmd_q;
        last_ok_d  = 1'b1;
        timer_d    = TIMER_LOAD;
        state_d    = REARM;
      end
      REARM: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end
    if (push_en) begin
      mem_d[wr_ptr_q] = {rpt_q, cmd_q};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end
    case ({push_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Head and valid are precomputed so the consumer sees flop outputs.
    valid_d = (count_d != '0);
    head_d  = mem_d[rd_ptr_d];
    rearm_d = (state_d == REARM);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET) begin
    if (RESET) begin
      state_q     <= IDLE;
      in_valid_q  <= 1'b0;
      in_repeat_q <= 1'b0;
      in_addr_q   <= '0;
      in_cmd_q    <= '0;
      in_inv_q    <= '0;
      addr_q      <= '0;
      cmd_q       <= '0;
      inv_q       <= '0;
      rpt_q       <= 1'b0;
      last_cmd_q  <= '0;
      last_ok_q   <= 1'b0;
      timer_q     <= '0;
      led_q       <= '0;
      err_q       <= '0;
      ovf_q       <= 1'b0;
      rearm_q     <= 1'b0;
      valid_q     <= 1'b0;
      head_q      <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      for (int k = 0; k < FIFO_DEPTH; k++) begin
        mem_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      in_valid_q  <= in_valid_d;
      in_repeat_q <= in_repeat_d;
      in_addr_q   <= in_addr_d;
      in_cmd_q    <= in_cmd_d;
      in_inv_q    <= in_inv_d;
      addr_q      <= addr_d;
      cmd_q       <= cmd_d;
      inv_q       <= inv_d;
      rpt_q       <= rpt_d;
      last_cmd_q  <= last_cmd_d;
      last_ok_q   <= last_ok_d;
      timer_q     <= timer_d;
      led_q       <= led_d;
      err_q       <= err_d;
      ovf_q       <= ovf_d;
      rearm_q     <= rearm_d;
      valid_q     <= valid_d;
      head_q      <= head_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      mem_q       <= mem_d;
    end
  end

  assign dec_rearm  = rearm_q;
  assign cmd_valid  = valid_q;
  assign cmd_data   = head_q[7:0];
  assign cmd_repeat = head_q[8];
  assign LEDR       = led_q;
  assign err_count  = err_q;
  assign overflow   = ovf_q;

endmodule

// File: tb/tb_ir_cmd_scheduler.sv
// tb/tb_ir_cmd_scheduler.sv - self-checking bench for ir_cmd_scheduler
module tb_ir_cmd_scheduler;

  localparam int W     = 100;
  localparam int DEPTH = 4;

  logic       CLOCK_50;
  logic       RESET;
  logic       dec_valid;
  logic [7:0] dec_addr;
  logic [7:0] dec_cmd;
  logic [7:0] dec_cmd_inv;
  logic       dec_repeat;
  logic       dec_rearm;
  logic       cmd_valid;
  logic [7:0] cmd_data;
  logic       cmd_repeat;
  logic       cmd_ready;
  logic [7:0] LEDR;
  logic [7:0] err_count;
  logic       overflow;

  ir_cmd_scheduler #(
    .FIFO_DEPTH(DEPTH),
    .REPEAT_WINDOW(W),
    .ADDR_FILTER(1'b1),
    .ADDR_MATCH(8'h00)
  ) dut (
    .CLOCK_50(CLOCK_50),
    .RESET(RESET),
    .dec_valid(dec_valid),
    .dec_addr(dec_addr),
    .dec_cmd(dec_cmd),
    .dec_cmd_inv(dec_cmd_inv),
    .dec_repeat(dec_repeat),
    .dec_rearm(dec_rearm),
    .cmd_valid(cmd_valid),
    .cmd_data(cmd_data),
    .cmd_repeat(cmd_repeat),
    .cmd_ready(cmd_ready),
    .LEDR(LEDR),
    .err_count(err_count),
    .overflow(overflow)
  );

  initial CLOCK_50 = 1'b0;
  always #10 CLOCK_50 = ~CLOCK_50;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [8:0] exp_q[$];
  logic [7:0] m_led;
  int         m_err;
  logic       m_ovf;
  logic [7:0] m_last;
  bit         m_have;
  int         m_push_cyc;
  int         cyc;
  int         rearm_cnt;
  bit         rand_ready;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_push(input logic [8:0] e);
    if (exp_q.size() < DEPTH) exp_q.push_back(e);
    else m_ovf = 1'b1;
  endtask

  task automatic check_pop();
    logic [8:0] e;
    if (exp_q.size() == 0) begin
      chk("pop_unexpected", 32'(cmd_valid), 32'd0);
    end else begin
      e = exp_q.pop_front();
      chk("pop_data", 32'(cmd_data), 32'(e[7:0]));
      chk("pop_rpt", 32'(cmd_repeat), 32'(e[8]));
    end
  endtask

  // Called at a negedge; a handshake visible now completes on the next posedge.
  task automatic step();
    if (rand_ready) cmd_ready = 1'($urandom_range(0, 1));
    if (cmd_valid === 1'b1 && cmd_ready === 1'b1) check_pop();
    @(posedge CLOCK_50);
    cyc++;
    @(negedge CLOCK_50);
    if (dec_rearm === 1'b1) rearm_cnt++;
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step();
  endtask

  task automatic send_frame(input logic [7:0] a, input logic [7:0] c, input logic [7:0] i,
                            input bit pop_at_push);
    int  r0;
    bit  pass;
    pass = ((c ^ i) == 8'hFF) && (a == 8'h00);
    r0 = rearm_cnt;
    dec_valid = 1'b1; dec_addr = a; dec_cmd = c; dec_cmd_inv = i;
    step();                                    // edge N
    dec_valid = 1'b0;
    dec_addr = 8'($urandom); dec_cmd = 8'($urandom); dec_cmd_inv = 8'($urandom);
    step();                                    // edge N+1
    chk("err_n1", 32'(err_count), 32'(m_err));
    step();                                    // edge N+2
    if (!pass && m_err < 255) m_err++;
    chk("err_n2", 32'(err_count), 32'(m_err));
    chk("led_n2", 32'(LEDR), 32'(m_led));
    if (pop_at_push) cmd_ready = 1'b1;
    step();                                    // edge N+3
    if (pop_at_push) cmd_ready = 1'b0;
    if (pass) begin
      model_push({1'b0, c});
      m_led = c; m_last = c; m_have = 1'b1; m_push_cyc = cyc;
    end
    chk("led_n3", 32'(LEDR), 32'(m_led));
    chk("ovf", 32'(overflow), 32'(m_ovf));
    chk("valid_n3", 32'(cmd_valid), 32'(exp_q.size() != 0));
    chk("rearm_frame", rearm_cnt - r0, 32'd1);
  endtask

  task automatic send_repeat();
    int r0;
    int m;
    bit hon;
    r0 = rearm_cnt;
    dec_repeat = 1'b1;
    step();                                    // edge M
    dec_repeat = 1'b0;
    m = cyc;
    hon = m_have && ((m - m_push_cyc) < W);
    step();
    step();                                    // edge M+2
    if (hon) begin
      model_push({1'b1, m_last});
      m_led = m_last; m_push_cyc = cyc;
    end
    chk("led_rpt", 32'(LEDR), 32'(m_led));
    chk("err_rpt", 32'(err_count), 32'(m_err));
    chk("ovf_rpt", 32'(overflow), 32'(m_ovf));
    chk("valid_rpt", 32'(cmd_valid), 32'(exp_q.size() != 0));
    chk("rearm_rpt", rearm_cnt - r0, 32'd1);
  endtask

  task automatic drain();
    cmd_ready = 1'b1;
    for (int k = 0; k < 16 && exp_q.size() != 0; k++) step();
    chk("drain_left", exp_q.size(), 32'd0);
    chk("drain_valid", 32'(cmd_valid), 32'd0);
    cmd_ready = 1'b0;
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_led"}, 32'(LEDR), 32'd0);
    chk({tag, "_err"}, 32'(err_count), 32'd0);
    chk({tag, "_ovf"}, 32'(overflow), 32'd0);
    chk({tag, "_valid"}, 32'(cmd_valid), 32'd0);
    chk({tag, "_rearm"}, 32'(dec_rearm), 32'd0);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  logic [7:0] ra, rc, ri;
  int         kind;
  int         r0;

  initial begin
    RESET = 1'b1; dec_valid = 1'b0; dec_addr = '0; dec_cmd = '0; dec_cmd_inv = '0;
    dec_repeat = 1'b0; cmd_ready = 1'b0; rand_ready = 1'b0;
    m_led = '0; m_err = 0; m_ovf = 1'b0; m_last = '0; m_have = 1'b0; m_push_cyc = 0;
    cyc = 0; rearm_cnt = 0;
    repeat (2) @(negedge CLOCK_50);
    check_zero("reset");
    RESET = 1'b0;
    step();
    check_zero("post_reset");

    // Good frame, consumer ready
    cmd_ready = 1'b1;
    send_frame(8'h00, 8'h45, 8'hBA, 1'b0);
    step();
    chk("t1_drained", 32'(cmd_valid), 32'd0);
    chk("t1_rearm_low", 32'(dec_rearm), 32'd0);

    // Corrupt frame
    send_frame(8'h00, 8'h45, 8'hBB, 1'b0);

    // Address filter
    send_frame(8'h01, 8'h45, 8'hBA, 1'b0);
    send_frame(8'h00, 8'h45, 8'hBA, 1'b0);
    idle(2);

    // Repeat inside and outside the window
    send_frame(8'h00, 8'h18, 8'hE7, 1'b0);
    idle(46);
    send_repeat();
    idle(150);
    send_repeat();
    drain();

    // FIFO full with consumer stalled
    for (int k = 1; k <= 5; k++) send_frame(8'h00, 8'(k), ~8'(k), 1'b0);
    chk("full_ovf", 32'(overflow), 32'd1);
    chk("full_led", 32'(LEDR), 32'h05);
    drain();

    // Full FIFO with a pop on the push edge still accepts the new entry
    for (int k = 1; k <= 4; k++) send_frame(8'h00, 8'hA0 + 8'(k), ~(8'hA0 + 8'(k)), 1'b0);
    send_frame(8'h00, 8'hA5, 8'h5A, 1'b1);
    drain();

    // Randomized traffic
    rand_ready = 1'b1;
    for (int e = 0; e < 40; e++) begin
      kind = $urandom_range(0, 9);
      if (kind < 7) begin
        rc = 8'($urandom);
        ra = ($urandom_range(0, 5) == 0) ? 8'($urandom_range(1, 255)) : 8'h00;
        ri = ($urandom_range(0, 3) == 0) ? 8'($urandom) : ~rc;
        send_frame(ra, rc, ri, 1'b0);
      end else begin
        send_repeat();
      end
      if ($urandom_range(0, 9) == 0) idle(110);
      else idle($urandom_range(0, 4));
    end
    rand_ready = 1'b0;
    drain();

    // Error counter saturation
    for (int k = 0; k < 300; k++) send_frame(8'h00, 8'h45, 8'hBB, 1'b0);
    chk("err_sat", 32'(err_count), 32'd255);

    // Reset while a frame sits in CHECK
    send_frame(8'h00, 8'h3C, 8'hC3, 1'b0);
    dec_valid = 1'b1; dec_addr = 8'h00; dec_cmd = 8'h77; dec_cmd_inv = 8'h88;
    step();
    dec_valid = 1'b0;
    step();
    r0 = rearm_cnt;
    RESET = 1'b1;
    #1;
    check_zero("rst_mid");
    @(negedge CLOCK_50);
    chk("rst_hold_rearm", 32'(dec_rearm), 32'd0);
    RESET = 1'b0;
    exp_q.delete();
    m_led = '0; m_err = 0; m_ovf = 1'b0; m_have = 1'b0;
    idle(4);
    chk("rst_no_rearm", rearm_cnt - r0, 32'd0);
    check_zero("rst_after");

    send_frame(8'h00, 8'h5A, 8'hA5, 1'b0);
    drain();
    idle(2);
    chk("final_rearm_low", 32'(dec_rearm), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
